// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end.
package if_fetch_queue_pkg;

  localparam int unsigned DEFAULT_WORD_LEN = 32;
  localparam int unsigned PC_INCR          = 4;
  localparam logic [DEFAULT_WORD_LEN-1:0] NOP_INST = '0;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous FIFO holding {instruction, pc} entries for the fetch queue.
// Clear has priority over push and pop; the head is read combinationally.
module if_inst_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [DATA_W-1:0] head_data,
  output logic [CW-1:0]     count,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: credit-limited pipelined imem requests,
// in-order response buffering, decode hazard hold and branch flush.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned          WORD_LEN    = DEFAULT_WORD_LEN,
  parameter int unsigned          QUEUE_DEPTH = 4,
  parameter logic [WORD_LEN-1:0]  RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  input  logic                hazard_detected,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_target,
  output logic                inst_valid,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_out
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [WORD_LEN-1:0]   fetch_pc;
  logic [WORD_LEN-1:0]   resp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard_cnt;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [2*WORD_LEN-1:0] head_data;
  logic [CW:0]           credits_used;
  logic                  accept;
  logic                  drop;
  logic                  push;
  logic                  pop;

  // In-flight requests reserve a queue slot, so a returning word always fits.
  assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req     = rst & ~br_taken & (credits_used < (CW+1)'(QUEUE_DEPTH));
  assign imem_addr    = fetch_pc;
  assign accept       = imem_req & imem_gnt;

  assign drop = imem_rvalid & (discard_cnt != '0);
  assign push = imem_rvalid & ~drop & ~br_taken;
  assign pop  = inst_valid & ~hazard_detected & ~br_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (br_taken) begin
      fetch_pc    <= br_target;
      resp_pc     <= br_target;
      outstanding <= outstanding - CW'(imem_rvalid);
      // Every word still in flight is stale; earlier discards are a subset of these.
      discard_cnt <= outstanding - CW'(imem_rvalid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + WORD_LEN'(PC_INCR);
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (drop) discard_cnt <= discard_cnt - CW'(1);
      if (push) resp_pc <= resp_pc + WORD_LEN'(PC_INCR);
    end
  end

  if_inst_fifo #(
    .DATA_W (2 * WORD_LEN),
    .DEPTH  (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data ({imem_rdata, resp_pc}),
    .pop       (pop),
    .clear     (br_taken),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign inst_valid  = ~fifo_empty;
  assign instruction = inst_valid ? head_data[2*WORD_LEN-1:WORD_LEN] : WORD_LEN'(NOP_INST);
  assign pc_out      = inst_valid ? head_data[WORD_LEN-1:0] : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a small in-order memory model feeds
// responses, expected {instruction, pc} entries are queued and compared at the head.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        hazard_detected;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } mem_ent_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_ent_t;

  mem_ent_t    mem_q[$];
  exp_ent_t    exp_q[$];
  logic [31:0] model_pc;
  bit          gnt_en;
  bit          resp_en;
  bit          rand_mode;
  int          accepts;
  int          total;
  int          bad;

  if_fetch_queue #(
    .WORD_LEN    (32),
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .hazard_detected (hazard_detected),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .inst_valid      (inst_valid),
    .instruction     (instruction),
    .pc_out          (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: check the head, drive the next cycle, update the model.
  task automatic step(input bit hz, input bit br, input logic [31:0] tgt);
    bit       exp_valid;
    bit       exp_req;
    mem_ent_t m;
    exp_ent_t e;
    exp_valid = (exp_q.size() != 0);
    check("inst_valid", inst_valid, exp_valid);
    check("instruction", instruction, exp_valid ? exp_q[0].inst : 32'h0);
    check("pc_out", pc_out, exp_valid ? exp_q[0].pc : 32'h0);

    hazard_detected = hz;
    br_taken        = br;
    br_target       = tgt;
    imem_gnt        = rand_mode ? ($urandom_range(0, 1) == 1) : gnt_en;
    imem_rvalid     = (rand_mode ? ($urandom_range(0, 2) != 0) : resp_en) && (mem_q.size() > 0);
    imem_rdata      = imem_rvalid ? (32'h2000_0000 | mem_q[0].addr) : 32'hdead_beef;
    #1;
    exp_req = !br && ((exp_q.size() + mem_q.size()) < 4);
    check("imem_req", imem_req, exp_req);
    check("imem_addr", imem_addr, model_pc);

    if (exp_valid && !hz && !br) void'(exp_q.pop_front());
    if (imem_rvalid) begin
      m = mem_q.pop_front();
      if (!br && !m.stale) begin
        e.inst = 32'h2000_0000 | m.addr;
        e.pc   = m.addr;
        exp_q.push_back(e);
      end
    end
    if (br) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      model_pc = tgt;
    end
    if (exp_req && imem_gnt) begin
      m.addr  = model_pc;
      m.stale = 1'b0;
      mem_q.push_back(m);
      model_pc = model_pc + 32'd4;
      accepts++;
    end
    @(negedge clk);
  endtask

  task automatic wait_head(input string tag, input logic [31:0] exp_pc);
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) break;
      step(1'b0, 1'b0, 32'h0);
    end
    check({tag, "_valid"}, inst_valid, 32'h1);
    check(tag, pc_out, exp_pc);
    check({tag, "_inst"}, instruction, 32'h2000_0000 | exp_pc);
  endtask

  task automatic idle_inputs();
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;
    hazard_detected = 1'b0;
    br_taken        = 1'b0;
    br_target       = 32'h0;
  endtask

  task automatic model_reset();
    mem_q.delete();
    exp_q.delete();
    model_pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int valid_cnt;
    total = 0; bad = 0; accepts = 0;
    gnt_en = 1'b0; resp_en = 1'b0; rand_mode = 1'b0;
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    check("rst_req", imem_req, 32'h0);
    check("rst_valid", inst_valid, 32'h0);
    check("rst_inst", instruction, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Credit limit: grants but no responses.
    gnt_en = 1'b1;
    repeat (6) step(1'b0, 1'b0, 32'h0);
    check("credit_accepts", accepts, 32'd4);
    check("credit_req_off", imem_req, 32'h0);

    // Release responses while decode stalls: queue fills, no more requests.
    resp_en = 1'b1;
    repeat (6) step(1'b1, 1'b0, 32'h0);
    check("full_req_off", imem_req, 32'h0);
    check("full_accepts", accepts, 32'd4);

    // Pop pc 0 and 4, then hold pc 8 under hazard.
    repeat (2) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("hz_pc", pc_out, 32'h8);
      step(1'b1, 1'b0, 32'h0);
    end
    check("hz_pc_last", pc_out, 32'h8);
    step(1'b0, 1'b0, 32'h0);
    check("hz_release_pc", pc_out, 32'hc);

    // Flush with requests still in flight.
    resp_en = 1'b0;
    repeat (2) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    check("br_valid", inst_valid, 32'h0);
    check("br_addr", imem_addr, 32'h100);
    resp_en = 1'b1;
    wait_head("br_first_pc", 32'h100);

    // Flush during hazard with a same-cycle response.
    repeat (2) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40);
    check("brhz_valid", inst_valid, 32'h0);
    check("brhz_addr", imem_addr, 32'h40);
    wait_head("brhz_first_pc", 32'h40);

    // Steady stream: one instruction per cycle once filled.
    repeat (6) step(1'b0, 1'b0, 32'h0);
    valid_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) valid_cnt++;
      step(1'b0, 1'b0, 32'h0);
    end
    check("stream_rate", valid_cnt, 32'd10);

    // Random grant stalls, response gaps and hazards.
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) step(($urandom_range(0, 3) == 0), 1'b0, 32'h0);
    rand_mode = 1'b0;
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req", imem_req, 32'h0);
    check("arst_valid", inst_valid, 32'h0);
    check("arst_inst", instruction, 32'h0);
    check("arst_pc", pc_out, 32'h0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_req", imem_req, 32'h1);
    check("post_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    wait_head("post_rst_pc", 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
